// File: rtl/result_unloader.sv
// Deskews lane-staggered result rows, buffers whole rows in a FIFO and streams them out element by element.
// Optional row index output on out_row when UNLOAD_ROWCNT_EN is defined.
module result_unloader #(
   parameter int DEP        = 8,
   parameter int COL        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   input  logic [DEP-1:0]                       data_in [0:COL-1],
   output logic [DEP-1:0]                       out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_last,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
`ifdef UNLOAD_ROWCNT_EN
   output logic [15:0]                          out_row,
`endif
   output logic                                 overflow
);

   localparam int LVL_W = $clog2(FIFO_DEPTH+1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int IDX_W = (COL > 1) ? $clog2(COL) : 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL-1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   logic [DEP-1:0]   aligned [0:COL-1];
   logic [COL-2:0]   vld_p;
   logic [DEP-1:0]   mem     [0:FIFO_DEPTH-1][0:COL-1];
   logic [DEP-1:0]   row     [0:COL-1];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level_nxt;
   logic [IDX_W-1:0] idx, idx_inc;
   logic             push, pop, push_ok;
   state_t           state;

   // Lane k waits COL-1-k cycles so all lanes line up with the last one
   for (genvar k = 0; k < COL-1; k++) begin : g_dly
      logic [DEP-1:0] chain [0:COL-2-k];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= COL-2-k; s++) chain[s] <= '0;
         end else begin
            chain[0] <= data_in[k];
            for (int s = 1; s <= COL-2-k; s++) chain[s] <= chain[s-1];
         end
      end
      assign aligned[k] = chain[COL-2-k];
   end
   assign aligned[COL-1] = data_in[COL-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= in_valid;
         for (int s = 1; s < COL-1; s++) vld_p[s] <= vld_p[s-1];
      end
   end

   assign push    = vld_p[COL-2];
   assign pop     = (state != SEND) && (level != '0);
   assign push_ok = push && ((level != FULL_LVL) || pop);
   assign idx_inc = idx + 1'b1;

   always_comb begin
      level_nxt = level;
      if (push_ok && !pop)      level_nxt = level + 1'b1;
      else if (!push_ok && pop) level_nxt = level - 1'b1;
   end

   // Row FIFO: a push into a full FIFO only survives if the head leaves in the same cycle
   always_ff @(posedge clk) begin
      if (push_ok) begin
         for (int c = 0; c < COL; c++) mem[wr_ptr][c] <= aligned[c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

   // Serializer; IDLE pops directly so an idle unloader does not add a second bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         for (int c = 0; c < COL; c++) row[c] <= '0;
`ifdef UNLOAD_ROWCNT_EN
         out_row   <= '0;
`endif
      end else begin
         case (state)
            IDLE, LOAD: begin
               if (level != '0) begin
                  for (int c = 0; c < COL; c++) row[c] <= mem[rd_ptr][c];
                  out_data  <= mem[rd_ptr][0];
                  out_valid <= 1'b1;
                  out_last  <= (LAST_IDX == '0);
                  idx       <= '0;
                  state     <= SEND;
               end else begin
                  state <= IDLE;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (idx != LAST_IDX) begin
                     idx      <= idx_inc;
                     out_data <= row[idx_inc];
                     out_last <= (idx_inc == LAST_IDX);
                  end else begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= (level_nxt != '0) ? LOAD : IDLE;
`ifdef UNLOAD_ROWCNT_EN
                     out_row   <= out_row + 16'd1;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
